ma_wb_pipe: RTL and testbench
=============================

# ma_wb_pipe

Parametrised memory-access to write-back pipeline stage for the 32-bit RISC core. It replaces the free-running MA/WB latch with a valid/ready handshaked register, adds synchronous flush, and muxes the write-back data and destination register. It also keeps a saturating bubble counter for performance analysis. The block sits between the memory-access unit (upstream) and the register-file write port (downstream).

## Interface
Parameters:
- `DATA_W`, default 32: width of PC, ALU result, load result and write-back data.
- `RD_W`, default 4: register index width.
- `RA_IDX`, default 15: register written by `call`.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  DATA_W  PC of the instruction.
- `in_alu_result`  in  DATA_W  ALU output.
- `in_ld_result`  in  DATA_W  load data.
- `in_ctrl`  in  `ctrl_t`  packed control bits: is_ld, is_call, is_wb, is_st, is_beq, is_bgt, is_ret, is_imm, is_ubranch.
- `in_rd`  in  RD_W  destination register field.
- `flush`  in  1  synchronous kill of all held beats.
- `out_valid`  out  1  beat presented to write-back.
- `out_ready`  in  1  write-back consumes the beat.
- `out_instr`, `out_pc`, `out_ctrl`  out  32/DATA_W/`ctrl_t`  registered copies of the inputs.
- `out_wb_en`  out  1  `out_valid & out_ctrl.is_wb`.
- `out_wb_rd`  out  RD_W  `RA_IDX` if is_call, else the stored rd.
- `out_wb_data`  out  DATA_W  `pc+4` if is_call; else `ld_result` if is_ld; else `alu_result`.
- `bubble_count`  out  CNT_W  count of cycles with `out_valid=0`.

## Operation
- A beat transfers in when `in_valid & in_ready`, and transfers out when `out_valid & out_ready`.
- Main register: it loads when it is empty, or when its current beat leaves in the same cycle.
- Write-back mux:
  - Combinational from the held entry.
  - Priority is is_call > is_ld > ALU.
  - `pc+4` wraps modulo 2^DATA_W.
- Flush:
  - Clears every valid bit at the next edge.
  - Beats presented in the flush cycle are dropped.
  - Data registers are not cleared.
- Bubble counter:
  - Increments every cycle `out_valid=0`, flush cycles included.
  - Saturates at 2^CNT_W−1 and does not wrap.
- Stall: while `out_ready=0` with valid data held, all outputs stay stable.
- Reset values:
  - All valid bits 0, so `out_valid=0` and `out_wb_en=0`.
  - `bubble_count=0`.
  - Data and ctrl registers 0, so `out_wb_rd=0` and `out_wb_data=0`.
  - `in_ready=1`.
- Reset asserted mid-stream discards held beats immediately (asynchronous).

## Timing
- Latency is 1 cycle from input acceptance to `out_valid`.
- Throughput is 1 beat/cycle when `out_ready=1`.
- No combinational path from `in_*` to `out_*`.
- With `MA_WB_SKID_EN`:
  - `in_ready` is a pure register output.
  - No `out_ready`→`in_ready` path.
- Without `MA_WB_SKID_EN`: `in_ready = ~out_valid | out_ready` (combinational).
- Simultaneous flush and out-handshake: the outgoing beat counts as consumed and nothing remains valid.

## Configuration
`MA_WB_SKID_EN` controls the skid entry.

With `MA_WB_SKID_EN` defined:
- A second skid entry is compiled in and `in_ready` is registered, equal to `~skid_valid`.
- If a beat arrives while main is stalled, it lands in skid.
- When main drains, skid moves to main next cycle and `in_ready` returns to 1.
- Ordering is preserved: skid always drains before any new input.
- Capacity is 2 beats.

Without `MA_WB_SKID_EN`:
- Single entry, capacity 1 beat.
- `in_ready` as given in Timing.

## Structure
- Package `ma_wb_pkg` holds `ctrl_t` (packed struct, field order as listed), default `RA_IDX` and `PC_STEP=4`.
- Sub-module `ma_wb_entry`: one payload register (valid + data + ctrl + rd) with load enable and clear. The block instantiates it once, or twice with `MA_WB_SKID_EN`.
- Write-back mux and bubble counter stay in the top.

## Test plan
- **Reset.** Assert `Reset_n=0` mid-stream with 2 beats held → `out_valid=0`, `bubble_count=0`, `in_ready=1` immediately, before any clock edge.
- **Streaming.** `out_ready=1`, 4 back-to-back ALU beats with alu_result 0x10..0x13 → out_wb_data 0x10..0x13 on consecutive cycles, 1-cycle latency, bubble_count unchanged once streaming.
- **Write-back mux.** Call beat with pc=0xFFFF_FFFC, rd=3 → out_wb_rd=15, out_wb_data=0x0 (wrap). Load beat with ld_result=0xDEAD_BEEF, alu=0x40 → out_wb_data=0xDEAD_BEEF.
- **Stall (skid enabled).** Hold `out_ready=0` and send beats A,B → A held stable, B in skid, `in_ready=0` next cycle, C not accepted. Release → A, B, C emerge in order.
- **Flush.** Flush with 2 beats held and in_valid=1 → `out_valid=0` next cycle, no held or incoming beat appears later.
- **Saturation.** CNT_W=4, idle 20 cycles after reset → bubble_count=15 and stays 15.

Source files
------------

// File: rtl/ma_wb_pkg.sv
// Shared types and constants for the MA->WB pipeline stage.
package ma_wb_pkg;

    typedef struct packed {
        logic is_ld;
        logic is_call;
        logic is_wb;
        logic is_st;
        logic is_beq;
        logic is_bgt;
        logic is_ret;
        logic is_imm;
        logic is_ubranch;
    } ctrl_t;

    localparam int DEF_RA_IDX = 15;
    localparam int PC_STEP    = 4;
    localparam int INSTR_W    = 32;

endpackage

// File: rtl/ma_wb_entry.sv
// One payload slot of the MA->WB stage: a valid bit plus a flat payload vector.
// Clear drops the valid bit only; the payload keeps its last loaded value.
module ma_wb_entry #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic         clear,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else begin
            if (clear) begin
                q_valid <= 1'b0;
            end else if (load) begin
                q_valid <= d_valid;
            end
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ma_wb_pipe.sv
// Handshaked MA->WB pipeline register with flush, write-back mux and bubble counter.
// Define MA_WB_SKID_EN to add a skid entry and register in_ready.
module ma_wb_pipe
    import ma_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int RA_IDX = DEF_RA_IDX,
    parameter int CNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_ld_result,
    input  ctrl_t              in_ctrl,
    input  logic [RD_W-1:0]    in_rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_pc,
    output ctrl_t              out_ctrl,
    output logic               out_wb_en,
    output logic [RD_W-1:0]    out_wb_rd,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam int PAY_W = INSTR_W + 3 * DATA_W + $bits(ctrl_t) + RD_W;

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  main_pay;
    logic [PAY_W-1:0]  main_d;
    logic              main_valid;
    logic              main_free;
    logic              main_d_valid;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_ld;
    logic [RD_W-1:0]   out_rd;

    assign in_pay = {in_instr, in_pc, in_alu_result, in_ld_result, in_ctrl, in_rd};
    assign {out_instr, out_pc, out_alu, out_ld, out_ctrl, out_rd} = main_pay;

    // Main slot can take a new beat when empty or when its beat leaves this cycle.
    assign main_free = ~main_valid | out_ready;

`ifdef MA_WB_SKID_EN
    logic             skid_valid;
    logic [PAY_W-1:0] skid_pay;

    // Skid captures only while main is stuck; it always drains ahead of new input.
    ma_wb_entry #(.W(PAY_W)) u_skid (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (main_free | ~skid_valid),
        .clear   (flush),
        .d_valid (~main_free & in_valid),
        .d       (in_pay),
        .q_valid (skid_valid),
        .q       (skid_pay)
    );

    assign in_ready     = ~skid_valid;
    assign main_d_valid = skid_valid | in_valid;
    assign main_d       = skid_valid ? skid_pay : in_pay;
`else
    assign in_ready     = main_free;
    assign main_d_valid = in_valid;
    assign main_d       = in_pay;
`endif

    ma_wb_entry #(.W(PAY_W)) u_main (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (main_free),
        .clear   (flush),
        .d_valid (main_d_valid),
        .d       (main_d),
        .q_valid (main_valid),
        .q       (main_pay)
    );

    assign out_valid = main_valid;
    assign out_wb_en = main_valid & out_ctrl.is_wb;
    assign out_wb_rd = out_ctrl.is_call ? RD_W'(RA_IDX) : out_rd;

    always_comb begin
        out_wb_data = out_alu;
        if (out_ctrl.is_call) begin
            out_wb_data = out_pc + DATA_W'(PC_STEP);
        end else if (out_ctrl.is_ld) begin
            out_wb_data = out_ld;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bubble_count <= '0;
        end else if (!main_valid && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ma_wb_pipe.sv
// Directed self-checking bench for ma_wb_pipe (bubble counter built 4 bits wide).
module tb_ma_wb_pipe;
    import ma_wb_pkg::*;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;
    localparam int CNT_W  = 4;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_ld_result;
    ctrl_t             in_ctrl;
    logic [RD_W-1:0]   in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_pc;
    ctrl_t             out_ctrl;
    logic              out_wb_en;
    logic [RD_W-1:0]   out_wb_rd;
    logic [DATA_W-1:0] out_wb_data;
    logic [CNT_W-1:0]  bubble_count;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    ctrl_t c_none;
    ctrl_t c_alu;
    ctrl_t c_call;
    ctrl_t c_ld;
    ctrl_t c_st;

    ma_wb_pipe #(.DATA_W(DATA_W), .RD_W(RD_W), .RA_IDX(15), .CNT_W(CNT_W)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_alu_result (in_alu_result),
        .in_ld_result  (in_ld_result),
        .in_ctrl       (in_ctrl),
        .in_rd         (in_rd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ctrl      (out_ctrl),
        .out_wb_en     (out_wb_en),
        .out_wb_rd     (out_wb_rd),
        .out_wb_data   (out_wb_data),
        .bubble_count  (bubble_count)
    );

    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] ld,
                                 input ctrl_t c, input logic [3:0] rd);
        in_valid      = v;
        in_instr      = instr;
        in_pc         = pc;
        in_alu_result = alu;
        in_ld_result  = ld;
        in_ctrl       = c;
        in_rd         = rd;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        c_none = '0;
        c_alu = '0;  c_alu.is_wb = 1'b1;
        c_call = '0; c_call.is_call = 1'b1; c_call.is_wb = 1'b1;
        c_ld = '0;   c_ld.is_ld = 1'b1;     c_ld.is_wb = 1'b1;
        c_st = '0;   c_st.is_st = 1'b1;

        Reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_bubble", bubble_count, 0);
        checkOutput("reset_wb_en", out_wb_en, 0);
        checkOutput("reset_wb_rd", out_wb_rd, 0);
        checkOutput("reset_wb_data", out_wb_data, 0);
        #1;
        Reset_n = 1'b1;

        tick(); tick(); tick();
        checkOutput("idle_bubble", bubble_count, 3);

        // Streaming: four ALU beats back to back, one cycle latency.
        applyStimulus(1'b1, 32'h100, 32'h1000, 32'h10, 32'h0, c_alu, 4'd2);
        #1;
        checkOutput("stream_no_comb_path", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 32'h1000 + 4 * i, 32'h10 + i, 32'h0, c_alu, 4'd2);
            tick();
            checkOutput("stream_valid", out_valid, 1);
            checkOutput("stream_data", out_wb_data, 32'h10 + i);
            checkOutput("stream_instr", out_instr, 32'h100 + i);
            checkOutput("stream_bubble", bubble_count, 4);
        end
        checkOutput("stream_wb_rd", out_wb_rd, 2);
        checkOutput("stream_wb_en", out_wb_en, 1);
        checkOutput("stream_in_ready", in_ready, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        tick();
        checkOutput("stream_drained", out_valid, 0);
        checkOutput("stream_bubble_after", bubble_count, 4);

        // Write-back mux: call with pc wrap, load priority over ALU, non-wb beat.
        applyStimulus(1'b1, 32'h200, 32'hFFFF_FFFC, 32'h55, 32'h66, c_call, 4'd3);
        tick();
        checkOutput("call_wb_rd", out_wb_rd, 15);
        checkOutput("call_wb_data", out_wb_data, 32'h0);
        checkOutput("call_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("call_wb_en", out_wb_en, 1);
        applyStimulus(1'b1, 32'h201, 32'h2000, 32'h40, 32'hDEAD_BEEF, c_ld, 4'd5);
        tick();
        checkOutput("ld_wb_data", out_wb_data, 32'hDEAD_BEEF);
        checkOutput("ld_wb_rd", out_wb_rd, 5);
        applyStimulus(1'b1, 32'h202, 32'h2004, 32'h77, 32'h88, c_st, 4'd6);
        tick();
        checkOutput("st_valid", out_valid, 1);
        checkOutput("st_wb_en", out_wb_en, 0);
        checkOutput("st_wb_data", out_wb_data, 32'h77);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        tick();
        checkOutput("mux_bubble", bubble_count, 5);

        // Stall: A held stable while the downstream is not ready.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h300, 32'h3000, 32'hA0, 32'h0, c_alu, 4'd1);
        tick();
        checkOutput("stall_a_valid", out_valid, 1);
        checkOutput("stall_a_data", out_wb_data, 32'hA0);
`ifdef MA_WB_SKID_EN
        checkOutput("stall_skid_ready", in_ready, 1);
        applyStimulus(1'b1, 32'h301, 32'h3004, 32'hB0, 32'h0, c_alu, 4'd1);
        tick();
        checkOutput("stall_b_skid_ready", in_ready, 0);
        checkOutput("stall_a_stable1", out_wb_data, 32'hA0);
        applyStimulus(1'b1, 32'h302, 32'h3008, 32'hC0, 32'h0, c_alu, 4'd1);
        tick();
        checkOutput("stall_c_blocked", in_ready, 0);
        checkOutput("stall_a_stable2", out_wb_data, 32'hA0);
        out_ready = 1'b1;
        #1;
        checkOutput("stall_ready_registered", in_ready, 0);
        tick();
        checkOutput("stall_b_out", out_wb_data, 32'hB0);
        checkOutput("stall_ready_back", in_ready, 1);
        tick();
        checkOutput("stall_c_out", out_wb_data, 32'hC0);
`else
        checkOutput("stall_not_ready", in_ready, 0);
        applyStimulus(1'b1, 32'h301, 32'h3004, 32'hB0, 32'h0, c_alu, 4'd1);
        tick();
        checkOutput("stall_a_stable1", out_wb_data, 32'hA0);
        checkOutput("stall_still_not_ready", in_ready, 0);
        tick();
        checkOutput("stall_a_stable2", out_wb_data, 32'hA0);
        out_ready = 1'b1;
        #1;
        checkOutput("stall_ready_comb", in_ready, 1);
        tick();
        checkOutput("stall_b_out", out_wb_data, 32'hB0);
`endif
        checkOutput("stall_valid_after", out_valid, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        tick();
        checkOutput("stall_drained", out_valid, 0);
        checkOutput("stall_bubble", bubble_count, 6);

        // Flush with beats held and a beat on the input.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h400, 32'h4000, 32'hD0, 32'h0, c_alu, 4'd7);
        tick();
        checkOutput("flush_d_valid", out_valid, 1);
`ifdef MA_WB_SKID_EN
        applyStimulus(1'b1, 32'h401, 32'h4004, 32'hE0, 32'h0, c_alu, 4'd7);
        tick();
        checkOutput("flush_e_skid", in_ready, 0);
`endif
        flush = 1'b1;
        applyStimulus(1'b1, 32'h402, 32'h4008, 32'hF0, 32'h0, c_alu, 4'd7);
        tick();
        checkOutput("flush_cleared", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        checkOutput("flush_bubble", bubble_count, 7);
        flush = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("flush_no_ghost", out_valid, 0);
        end
        checkOutput("flush_bubble_after", bubble_count, 10);

        // Saturation of the 4-bit bubble counter.
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_bubble", bubble_count, 15);
        tick(); tick(); tick();
        checkOutput("sat_hold", bubble_count, 15);

        // Asynchronous reset with beats held mid-stream.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h500, 32'h5000, 32'h99, 32'h0, c_alu, 4'd4);
        tick();
`ifdef MA_WB_SKID_EN
        applyStimulus(1'b1, 32'h501, 32'h5004, 32'h9A, 32'h0, c_alu, 4'd4);
        tick();
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, c_none, 4'd0);
        checkOutput("prereset_valid", out_valid, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("areset_valid", out_valid, 0);
        checkOutput("areset_bubble", bubble_count, 0);
        checkOutput("areset_in_ready", in_ready, 1);
        checkOutput("areset_wb_data", out_wb_data, 0);
        checkOutput("areset_wb_en", out_wb_en, 0);
        #2;
        Reset_n = 1'b1;
        tick();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
